// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multiplexed seven-segment display driver. Scans N_DIGITS nibbles onto a
//   shared active-low segment bus, one active-low anode at a time.
//   Features: programmable slot prescaler, per-digit decimal points,
//   leading-zero blanking, PWM brightness, a tear-free shadow copy of the
//   value latched once per frame, and a one-cycle anode dead time at the
//   start of every slot to suppress ghosting.
//
// Ports
//   clock       system clock
//   reset       asynchronous, active-high reset
//   value       digit nibbles, nibble i = value[4i+3:4i], digit 0 rightmost
//   dp_in       decimal point request per digit, active-high
//   blank_lz    1 = blank leading zeros
//   brightness  PWM duty, 0 = dark, all-ones = always on
//   segments    {CA..CG}, active-low
//   dp          decimal point cathode, active-low
//   anodos      anode enables, active-low
//   frame_start one-cycle pulse when the shadow copy has just been reloaded
module seg7_scan_driver #(
  parameter int N_DIGITS = 8,
  parameter int PRESCALE = 100000,
  parameter int BRIGHT_W = 4,
  parameter int HEX_MODE = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     anodos,
  output logic                    frame_start
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PRE_W = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  // Nibble to active-low glyph {a,b,c,d,e,f,g}; A-F blank in BCD-only mode.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    if (HEX_MODE == 0 && nib > 4'h9) g = 7'b1111111;
    return g;
  endfunction

  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
  logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
  logic [N_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  fs_q, fs_d;

  logic                  tick, wrap, lit, zero_above, sel_blank, sel_dp;
  logic [3:0]            sel_nib;
  logic [N_DIGITS-1:0]   lz_blank;

  always_comb begin
    tick       = (presc_q == PRE_LAST);
    wrap       = tick && (idx_q == IDX_LAST);
    presc_d    = tick ? '0 : presc_q + PRE_W'(1);
    idx_d      = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    pwm_d      = pwm_q + BRIGHT_W'(1);
    shadow_d   = wrap ? value : shadow_q;
    dp_sh_d    = wrap ? dp_in : dp_sh_q;
    fs_d       = wrap;

    // Digit i is a leading zero when it and every digit above it are zero.
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above && (shadow_q[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_above;
    end

    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_nib   = shadow_q[4*i +: 4];
        sel_dp    = dp_sh_q[i];
        sel_blank = lz_blank[i];
      end
    end

    lit = (brightness == '1) || (pwm_q < brightness);

    // Anodes stay off during the first cycle of each slot (dead time).
    an_d = '1;
    if (lit && (presc_q != '0)) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (idx_q == IDX_W'(i)) an_d[i] = 1'b0;
      end
    end

    seg_d = (blank_lz && sel_blank) ? 7'b1111111 : decode(sel_nib);
    dp_d  = ~sel_dp;
  end

  // ---- state and output registers ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      idx_q    <= '0;
      pwm_q    <= '0;
      shadow_q <= '0;
      dp_sh_q  <= '0;
      seg_q    <= 7'b1111111;
      dp_q     <= 1'b1;
      an_q     <= '1;
      fs_q     <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      pwm_q    <= pwm_d;
      shadow_q <= shadow_d;
      dp_sh_q  <= dp_sh_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
      fs_q     <= fs_d;
    end
  end

  assign segments    = seg_q;
  assign dp          = dp_q;
  assign anodos      = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] value;
  logic [7:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  brightness;

  logic [6:0]  segments, segments_b;
  logic        dp, dp_b;
  logic [7:0]  anodos, anodos_b;
  logic        frame_start, frame_start_b;

  seg7_scan_driver #(.N_DIGITS(8), .PRESCALE(4), .BRIGHT_W(4), .HEX_MODE(1)) u_dut (
    .clock(clock), .reset(reset), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .brightness(brightness), .segments(segments),
    .dp(dp), .anodos(anodos), .frame_start(frame_start)
  );

  seg7_scan_driver #(.N_DIGITS(8), .PRESCALE(4), .BRIGHT_W(4), .HEX_MODE(0)) u_bcd (
    .clock(clock), .reset(reset), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .brightness(brightness), .segments(segments_b),
    .dp(dp_b), .anodos(anodos_b), .frame_start(frame_start_b)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int n     = 0;   // rising edges since reset release
  int cnt;
  int d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    n++;
  endtask

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      10: return 7'b0001000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Pins after edge nn show the state reached at edge nn-1 (full brightness).
  function automatic logic [7:0] an_full(input int nn);
    int s;
    logic [7:0] one;
    s   = nn - 1;
    one = 8'h01;
    if (s % 4 == 0) return 8'hFF;
    return ~(one << ((s / 4) % 8));
  endfunction

  function automatic int dig(input int nn);
    return ((nn - 1) / 4) % 8;
  endfunction

  initial begin
    reset = 1'b1; value = 32'h0; dp_in = 8'h00; blank_lz = 1'b0; brightness = 4'hF;
    #2;
    chk("rst_an", anodos, 8'hFF);
    chk("rst_seg", segments, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_fs", frame_start, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_hold_an", anodos, 8'hFF);
    chk("rst_hold_seg", segments_b, 7'h7F);

    // Scan order and frame timing; first frame shows the zeroed shadow.
    @(negedge clock);
    value = 32'h76543210;
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      chk($sformatf("scan_an n=%0d", n), anodos, an_full(n));
      chk($sformatf("scan_seg n=%0d", n), segments, (n <= 32) ? glyph(0) : glyph(dig(n)));
      chk($sformatf("scan_dp n=%0d", n), dp, 1'b1);
      chk($sformatf("scan_fs n=%0d", n), frame_start, (n == 32 || n == 64));
    end

    // Tear-free latch: mid-frame change must wait for the next frame.
    value = 32'h11111111;
    while (n < 96) step();
    for (int k = 0; k < 64; k++) begin
      step();
      if (n == 110) value = 32'h22222222;
      chk($sformatf("latch_seg n=%0d", n), segments, (n <= 128) ? glyph(1) : glyph(2));
      chk($sformatf("latch_fs n=%0d", n), frame_start, (n % 32 == 0));
    end

    // Leading-zero blanking with a decimal point on the top digit.
    value = 32'h00000120; blank_lz = 1'b1; dp_in = 8'h80;
    while (n < 192) step();
    for (int k = 0; k < 32; k++) begin
      step();
      d = dig(n);
      chk($sformatf("lz_seg n=%0d", n), segments,
          (d == 0) ? glyph(0) : (d == 1) ? glyph(2) : (d == 2) ? glyph(1) : 7'h7F);
      chk($sformatf("lz_dp n=%0d", n), dp, (d == 7) ? 1'b0 : 1'b1);
      chk($sformatf("lz_an n=%0d", n), anodos, an_full(n));
    end

    value = 32'h0;
    while (n < 256) step();
    for (int k = 0; k < 32; k++) begin
      step();
      d = dig(n);
      chk($sformatf("lz0_seg n=%0d", n), segments, (d == 0) ? glyph(0) : 7'h7F);
      chk($sformatf("lz0_dp n=%0d", n), dp, (d == 7) ? 1'b0 : 1'b1);
    end

    // Hex versus BCD-only rendering of nibble A.
    value = 32'h0000000A; blank_lz = 1'b0; dp_in = 8'h00;
    while (n < 320) step();
    for (int k = 0; k < 32; k++) begin
      step();
      d = dig(n);
      chk($sformatf("hex_seg n=%0d", n), segments, (d == 0) ? glyph(10) : glyph(0));
      chk($sformatf("bcd_seg n=%0d", n), segments_b, (d == 0) ? 7'h7F : glyph(0));
    end

    // Brightness 4: lit when pwm in 0..3, minus dead cycles -> 3 per 16.
    brightness = 4'd4;
    cnt = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      if (anodos != 8'hFF) cnt++;
      if (n == 354) chk("pwm_on", anodos, 8'hFE);
      if (n == 358) chk("pwm_off", anodos, 8'hFF);
    end
    chk("pwm4_count", cnt, 12);

    brightness = 4'd0;
    cnt = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      if (anodos != 8'hFF) cnt++;
    end
    chk("pwm0_count", cnt, 0);

    // Asynchronous reset in the middle of a slot.
    brightness = 4'hF;
    step();
    step();
    chk("pre_rst_an", anodos, 8'hFE);
    #2 reset = 1'b1;
    #1;
    chk("async_an", anodos, 8'hFF);
    chk("async_seg", segments, 7'h7F);
    chk("async_dp", dp, 1'b1);
    chk("async_fs", frame_start, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    step();
    chk("restart_an1", anodos, 8'hFF);
    chk("restart_seg1", segments, glyph(0));
    step();
    chk("restart_an2", anodos, 8'hFE);
    chk("restart_fs", frame_start, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
